// File: rtl/dft_feeder_pkg.sv
// Shared types, default sizing and helpers for the dft_feeder capture front end.
// Optional build macro used by the top: DFT_FEEDER_TEST_RAMP_EN.
package dft_feeder_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DATA_W_DEF     = 12;
  localparam int CHUNK_LEN_DEF  = 32;
  localparam int CHUNKS_N_DEF   = 256;
  localparam int FIFO_DEPTH_DEF = 64;

  localparam int SAMPLES_TOTAL = CHUNKS_N_DEF * CHUNK_LEN_DEF;
  localparam int CAP_CNT_W     = clog2(SAMPLES_TOTAL + 1);
  localparam int OUT_CNT_W     = (CHUNK_LEN_DEF > 1) ? clog2(CHUNK_LEN_DEF) : 1;

endpackage

// File: rtl/dft_feeder_fifo.sv
// First-word-fall-through FIFO; the output register is one of the DEPTH slots,
// so a slot is only freed once its sample has actually been handed downstream.
module feeder_fifo
  import dft_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              wr_ok;

  // Full is derived from registered pointers only; a same-cycle pop does not make room.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign wr_ok   = wr_en_i && !full_o;
  assign rd_ptr_d = (rd_en_i && out_valid_q) ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= (rd_ptr_d != wr_ptr_q);
      // The head slot is never rewritten while occupied, so reloading it during a stall holds the value.
      if (rd_ptr_d != wr_ptr_q) out_data_q <= mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  assign rd_data_o  = out_data_q;
  assign rd_valid_o = out_valid_q;

endmodule

// File: rtl/dft_feeder.sv
// Captures a CHUNKS_N x CHUNK_LEN sample window on trig and streams it to the dft.
// Define DFT_FEEDER_TEST_RAMP_EN to replace adc_data with an internal bring-up ramp.
module dft_feeder
  import dft_feeder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CHUNK_LEN  = CHUNK_LEN_DEF,
  parameter int CHUNKS_N   = CHUNKS_N_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              trig,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              last_out,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int SAMPLES_TOT = CHUNKS_N * CHUNK_LEN;
  localparam int CAP_W       = clog2(SAMPLES_TOT + 1);
  localparam int OUT_W       = (CHUNK_LEN > 1) ? clog2(CHUNK_LEN) : 1;
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(SAMPLES_TOT);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(CHUNK_LEN - 1);

  state_e            state_q, state_d;
  logic [CAP_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              fifo_wr_en, fifo_full, fifo_empty, fifo_valid, xfer;
  logic [DATA_W-1:0] wr_sample, fifo_data;

`ifdef DFT_FEEDER_TEST_RAMP_EN
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic              unused_adc;
  assign unused_adc = ^adc_data;
  assign wr_sample  = ramp_q;
`else
  assign wr_sample  = adc_data;
`endif

  assign xfer = fifo_valid && ready_in;

  always_comb begin
    state_d    = state_q;
    cap_cnt_d  = cap_cnt_q;
    out_cnt_d  = out_cnt_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    fifo_wr_en = 1'b0;
`ifdef DFT_FEEDER_TEST_RAMP_EN
    ramp_d     = ramp_q;
`endif
    if (xfer) out_cnt_d = (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = CAPTURE;
          cap_cnt_d  = '0;
          out_cnt_d  = '0;
          overflow_d = 1'b0;
`ifdef DFT_FEEDER_TEST_RAMP_EN
          ramp_d     = '0;
`endif
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          cap_cnt_d  = cap_cnt_q + 1'b1;
          fifo_wr_en = !fifo_full;
          if (fifo_full) overflow_d = 1'b1;
`ifdef DFT_FEEDER_TEST_RAMP_EN
          ramp_d     = ramp_q + 1'b1;
`endif
          if (cap_cnt_d == CAP_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Empty pointers mean every captured sample has completed its handshake.
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_cnt_q  <= '0;
      out_cnt_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef DFT_FEEDER_TEST_RAMP_EN
      ramp_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cap_cnt_q  <= cap_cnt_d;
      out_cnt_q  <= out_cnt_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
`ifdef DFT_FEEDER_TEST_RAMP_EN
      ramp_q     <= ramp_d;
`endif
    end
  end

  feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (fifo_wr_en),
    .wr_data_i  (wr_sample),
    .rd_en_i    (ready_in),
    .rd_data_o  (fifo_data),
    .rd_valid_o (fifo_valid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign data_out  = fifo_data;
  assign valid_out = fifo_valid;
  assign last_out  = fifo_valid && (out_cnt_q == OUT_LAST);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dft_feeder.sv
// Scoreboard bench for dft_feeder: 4 chunks x 32 samples through a 64-entry FIFO.
module tb_dft_feeder;

  localparam int DW    = 12;
  localparam int CL    = 32;
  localparam int CN    = 4;
  localparam int FD    = 64;
  localparam int TOTAL = CL * CN;

  logic          clk, rst;
  logic [DW-1:0] adc_data, data_out;
  logic          adc_valid, trig, valid_out, ready_in, last_out, busy, done, overflow;

  dft_feeder #(
    .DATA_W     (DW),
    .CHUNK_LEN  (CL),
    .CHUNKS_N   (CN),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .trig      (trig),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .last_out  (last_out),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int xfer_cnt     = 0;
  int done_cnt     = 0;
  int last_xfer_cyc = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] drv_sample(input int mode, input int k);
    logic [DW-1:0] v;
    v = DW'(k);
    if (mode == 4) begin
      case (k % 3)
        0:       v = 12'h800;
        1:       v = 12'h7FF;
        default: v = 12'h000;
      endcase
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_sample(input int mode, input int k);
`ifdef DFT_FEEDER_TEST_RAMP_EN
    return DW'(k);
`else
    return drv_sample(mode, k);
`endif
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: a transfer completes at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", valid_out, 0);
        end else begin
          check_eq("data", data_out, exp_q[0]);
          check_eq("last", last_out, (xfer_cnt % CL) == CL - 1);
          if (ready_in) begin
            $display("[TB] xfer %0d data=%0d last=%0d", xfer_cnt, data_out, last_out);
            void'(exp_q.pop_front());
            xfer_cnt++;
            last_xfer_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        check_eq("done_empty", exp_q.size(), 0);
        check_eq("done_latency", cyc - last_xfer_cyc, 2);
      end
    end
  end

  task automatic run_acq(input int mode, input int exp_ovf, input int exp_xfers);
    int  k, start_done, stall_left;
    bit  stall_done, drain_trig_done;
    @(posedge clk); #1;
    trig       = 1'b1;
    adc_valid  = 1'b1;
    adc_data   = 12'h5A5;
    ready_in   = (mode != 2);
    xfer_cnt   = 0;
    start_done = done_cnt;
    k = 0; stall_left = 0; stall_done = 0; drain_trig_done = 0;
    for (int c = 0; c < 3000 && done_cnt == start_done; c++) begin
      @(posedge clk); #1;
      trig      = 1'b0;
      adc_valid = 1'b1;
      if (k < TOTAL) begin
        adc_data = drv_sample(mode, k);
        if (mode != 2 || k < FD) exp_q.push_back(exp_sample(mode, k));
      end
      case (mode)
        1: begin
          if (stall_left > 0) begin
            ready_in = 1'b0;
            stall_left--;
          end else if (!stall_done && xfer_cnt == 10) begin
            ready_in = 1'b0;
            stall_left = 19;
            stall_done = 1'b1;
          end else begin
            ready_in = 1'b1;
          end
        end
        2: ready_in = (k >= TOTAL);
        3: begin
          ready_in = 1'b1;
          if (k == 20) check_eq("ovf_cleared", overflow, 0);
          if (k == 40) trig = 1'b1;
          if (k == TOTAL && !drain_trig_done) begin
            check_eq("busy_drain", busy, 1);
            trig = 1'b1;
            drain_trig_done = 1'b1;
          end
        end
        default: ready_in = 1'b1;
      endcase
      k++;
    end
    trig = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("done_count", done_cnt - start_done, 1);
    check_eq("xfer_total", xfer_cnt, exp_xfers);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("busy_idle", busy, 0);
    check_eq("queue_left", exp_q.size(), 0);
    $display("[TB] acquisition mode %0d: %0d transfers, overflow=%0d", mode, xfer_cnt, overflow);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, valid_out, 0);
    check_eq({tag, "_data"},  data_out, 0);
    check_eq({tag, "_last"},  last_out, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_ovf"},   overflow, 0);
  endtask

  task automatic reset_mid_capture();
    @(posedge clk); #1;
    trig = 1'b1; adc_valid = 1'b1; ready_in = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      trig = 1'b0;
      adc_data = drv_sample(0, k);
      exp_q.push_back(exp_sample(0, k));
    end
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_eq("post_rst_valid", valid_out, 0);
    end
    check_eq("post_rst_busy", busy, 0);
    $display("[TB] async reset mid-capture handled");
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; adc_valid = 1'b0; adc_data = '0; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    run_acq(0, 0, TOTAL);
    run_acq(1, 0, TOTAL);
    run_acq(2, 1, FD);
    run_acq(3, 0, TOTAL);
    reset_mid_capture();
    run_acq(4, 0, TOTAL);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
